// File: rtl/fifo_write_ctrl.sv
// rtl/fifo_write_ctrl.sv - write-side pointer, full/level flags and overflow for an async FIFO
module fifo_write_ctrl #(
    parameter int ADDR_W = 2
) (
    input  logic              clk_wr,
    input  logic              rst_wr_n,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rptr_gray_in,
    output logic              wr_fire,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow
);

    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    // Full when the write Gray pointer is one lap ahead: read pointer with its two MSBs flipped.
    localparam logic [PW-1:0] FULL_MASK = PW'(3 << (PW - 2));

    logic [PW-1:0] r_sync1;
    logic [PW-1:0] r_sync2;
    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wgray;
    logic          r_full;
    logic          r_almost_full;
    logic [PW-1:0] r_level;
    logic          r_overflow;

    logic          w_wr_fire;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_level_next;
    logic          w_full_next;
    logic          w_almost_full_next;

    always_comb begin
        w_rbin = '0;
        for (int i = 0; i < PW; i++) begin
            w_rbin[i] = ^(r_sync2 >> i);
        end
    end

    assign w_wr_fire          = wr_en & ~r_full;
    assign w_wbin_next        = r_wbin + {{(PW-1){1'b0}}, w_wr_fire};
    assign w_wgray_next       = w_wbin_next ^ (w_wbin_next >> 1);
    assign w_level_next       = w_wbin_next - w_rbin;
    assign w_full_next        = (w_wgray_next == (r_sync2 ^ FULL_MASK));
    assign w_almost_full_next = (w_level_next >= PW'(DEPTH - 1));

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_wbin        <= '0;
            r_wgray       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_level       <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_sync1       <= rptr_gray_in;
            r_sync2       <= r_sync1;
            r_wbin        <= w_wbin_next;
            r_wgray       <= w_wgray_next;
            r_full        <= w_full_next;
            r_almost_full <= w_almost_full_next;
            r_level       <= w_level_next;
            r_overflow    <= r_overflow | (wr_en & r_full);
        end
    end

    assign wr_fire     = w_wr_fire;
    assign waddr       = r_wbin[ADDR_W-1:0];
    assign wptr_gray   = r_wgray;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign wr_level    = r_level;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb/tb_fifo_write_ctrl.sv - directed and randomized check of fifo_write_ctrl against a count-based model
module tb_fifo_write_ctrl;

    localparam int ADDR_W = 2;
    localparam int PW     = ADDR_W + 1;

    logic              clk_wr = 1'b0;
    logic              rst_wr_n;
    logic              wr_en;
    logic [PW-1:0]     rptr_gray_in;
    logic              wr_fire;
    logic [ADDR_W-1:0] waddr;
    logic [PW-1:0]     wptr_gray;
    logic              full;
    logic              almost_full;
    logic [PW-1:0]     wr_level;
    logic              overflow;

    fifo_write_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk_wr       (clk_wr),
        .rst_wr_n     (rst_wr_n),
        .wr_en        (wr_en),
        .rptr_gray_in (rptr_gray_in),
        .wr_fire      (wr_fire),
        .waddr        (waddr),
        .wptr_gray    (wptr_gray),
        .full         (full),
        .almost_full  (almost_full),
        .wr_level     (wr_level),
        .overflow     (overflow)
    );

    always #5 clk_wr = ~clk_wr;

    int errors = 0;
    int checks = 0;

    // Model state: total accepted writes, reader position, and the read positions seen per edge.
    int wc;
    int rp;
    int m_lvl;
    bit m_full;
    bit m_ovf;
    int hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & 7;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_waddr"}, 32'(waddr), wc & 3);
        check({tag, "_wgray"}, 32'(wptr_gray), gray(wc & 7));
        check({tag, "_full"}, 32'(full), 32'(m_full));
        check({tag, "_afull"}, 32'(almost_full), 32'(m_lvl >= 3));
        check({tag, "_level"}, 32'(wr_level), m_lvl);
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        wr_en        = 1'b0;
        rp           = 0;
        rptr_gray_in = '0;
        rst_wr_n     = 1'b0;
        wc = 0; m_lvl = 0; m_full = 0; m_ovf = 0;
        hist.delete();
        #1;
        check_outputs("rst");
        check("rst_fire", 32'(wr_fire), 0);
        @(negedge clk_wr);
        rst_wr_n = 1'b1;
    endtask

    task automatic cycle(input bit we);
        int seen;
        wr_en        = we;
        rptr_gray_in = PW'(gray(rp & 7));
        #1;
        check("fire", 32'(wr_fire), 32'(we && !m_full));
        @(posedge clk_wr);
        if (we && m_full) m_ovf = 1;
        if (we && !m_full) wc++;
        hist.push_back(rp);
        if (hist.size() > 3) void'(hist.pop_front());
        seen   = (hist.size() == 3) ? hist[0] : 0;
        m_lvl  = (wc - seen) & 7;
        m_full = (m_lvl == 4);
        #1;
        check_outputs("cyc");
        @(negedge clk_wr);
    endtask

    int fill_gray[4] = '{1, 3, 2, 6};
    int gseq[8]      = '{0, 1, 3, 2, 6, 7, 5, 4};

    initial begin
        logic [PW-1:0] prev;
        rst_wr_n = 1'b1;
        wr_en = 1'b0;
        rptr_gray_in = '0;
        #2;
        do_reset();

        for (int i = 0; i < 4; i++) begin
            check("fill_waddr", 32'(waddr), i);
            cycle(1'b1);
            check("fill_gray", 32'(wptr_gray), fill_gray[i]);
            if (i == 2) check("fill_afull3", 32'(almost_full), 1);
        end
        check("fill_full4", 32'(full), 1);
        check("fill_level4", 32'(wr_level), 4);

        for (int i = 0; i < 3; i++) cycle(1'b1);
        check("ovf_gray", 32'(wptr_gray), 3'b110);
        check("ovf_set", 32'(overflow), 1);
        cycle(1'b0);
        check("ovf_sticky", 32'(overflow), 1);

        rp = 1;
        cycle(1'b0);
        check("rel_full1", 32'(full), 1);
        cycle(1'b0);
        check("rel_full2", 32'(full), 1);
        cycle(1'b0);
        check("rel_full3", 32'(full), 0);
        check("rel_level3", 32'(wr_level), 3);
        cycle(1'b1);
        check("rel_gray", 32'(wptr_gray), 3'b111);
        check("rel_refull", 32'(full), 1);

        do_reset();
        cycle(1'b1);
        cycle(1'b1);
        #2;
        do_reset();
        check("mid_waddr0", 32'(waddr), 0);
        cycle(1'b1);
        check("mid_first_wgray", 32'(wptr_gray), 1);

        do_reset();
        prev = wptr_gray;
        for (int i = 0; i < 16; i++) begin
            rp = wc;
            cycle(1'b1);
            check("wrap_gray", 32'(wptr_gray), gseq[(i + 1) % 8]);
            check("wrap_onebit", 32'($countones(prev ^ wptr_gray)), 1);
            prev = wptr_gray;
        end
        check("wrap_ovf", 32'(overflow), 0);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit we;
            we = ($urandom_range(0, 3) != 0);
            if (rp < wc && $urandom_range(0, 2) == 0) rp++;
            cycle(we);
        end

        #2;
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
